// File: rtl/acc_c_rob.sv
// Reorder buffer: tags forwarded accelerator requests and returns their responses in acceptance order.
// Optional macro ACC_C_ROB_BYPASS_EN forwards a response for the waiting head entry without storing it.
module acc_c_rob #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdWidth  = $clog2(Depth),
  localparam int unsigned ReqW     = AddrWidth + 32 + 3 * DataWidth,
  localparam int unsigned RspW     = 2 * DataWidth + 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ReqW-1:0]    slv_q_req_i,
  input  logic               slv_q_wb_i,
  input  logic               slv_q_valid_i,
  output logic               slv_q_ready_o,
  output logic [ReqW-1:0]    mst_q_req_o,
  output logic [IdWidth-1:0] mst_q_id_o,
  output logic               mst_q_valid_o,
  input  logic               mst_q_ready_i,
  input  logic [RspW-1:0]    mst_p_rsp_i,
  input  logic [IdWidth-1:0] mst_p_id_i,
  input  logic               mst_p_valid_i,
  output logic               mst_p_ready_o,
  output logic [RspW-1:0]    slv_p_rsp_o,
  output logic               slv_p_valid_o,
  input  logic               slv_p_ready_i,
  output logic               spurious_o
);

  localparam int unsigned CntWidth = IdWidth + 1;

  logic [Depth-1:0]    alloc_q, alloc_d;
  logic [Depth-1:0]    done_q, done_d;
  logic [RspW-1:0]     data_q [Depth];
  logic [IdWidth-1:0]  head_q, head_d;
  logic [IdWidth-1:0]  tail_q, tail_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                spurious_q, spurious_d;
  logic                full, blocked, push, pop, rsp_ok, bypass, store;

  // Only write-back requests need a slot; others pass through even when full.
  assign full          = (count_q == CntWidth'(Depth));
  assign blocked       = slv_q_wb_i & full;
  assign mst_q_req_o   = slv_q_req_i;
  assign mst_q_id_o    = tail_q;
  assign mst_q_valid_o = slv_q_valid_i & ~blocked;
  assign slv_q_ready_o = mst_q_ready_i & ~blocked;
  assign push          = slv_q_valid_i & slv_q_ready_o & slv_q_wb_i;

  assign mst_p_ready_o = 1'b1;
  assign rsp_ok        = mst_p_valid_i & alloc_q[mst_p_id_i] & ~done_q[mst_p_id_i];
  assign spurious_d    = mst_p_valid_i & ~rsp_ok;
  assign spurious_o    = spurious_q;

`ifdef ACC_C_ROB_BYPASS_EN
  assign bypass = rsp_ok & (mst_p_id_i == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign slv_p_valid_o = (alloc_q[head_q] & done_q[head_q]) | bypass;
  assign slv_p_rsp_o   = bypass ? mst_p_rsp_i : data_q[head_q];
  assign pop           = slv_p_valid_o & slv_p_ready_i;
  // A bypassed response that is accepted immediately never occupies storage.
  assign store         = rsp_ok & ~(bypass & pop);

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (store) begin
      done_d[mst_p_id_i] = 1'b1;
    end
    if (pop) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + IdWidth'(1);
    end
    if (push) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + IdWidth'(1);
    end
    count_d = count_q + CntWidth'(push) - CntWidth'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
    end
  end

  // Payload storage needs no reset; the done flags qualify it.
  always_ff @(posedge clk_i) begin
    if (store) begin
      data_q[mst_p_id_i] <= mst_p_rsp_i;
    end
  end

endmodule

// File: tb/tb_acc_c_rob.sv
// Self-checking bench for acc_c_rob: directed scenarios then random traffic against an in-order queue model.
module tb_acc_c_rob;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned REQW  = AW + 32 + 3 * DW;
  localparam int unsigned RSPW  = 2 * DW + 8;
`ifdef ACC_C_ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int              id;
    bit              done;
    logic [RSPW-1:0] data;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [REQW-1:0] req;
  logic            wb, qv, qr, pv, pr;
  logic [IW-1:0]   pid;
  logic [RSPW-1:0] prsp;
  logic            slv_q_ready_o, mst_q_valid_o, mst_p_ready_o, slv_p_valid_o, spurious_o;
  logic [REQW-1:0] mst_q_req_o;
  logic [IW-1:0]   mst_q_id_o;
  logic [RSPW-1:0] slv_p_rsp_o;

  ent_t        rob[$];
  int          next_id;
  bit          exp_spur;
  logic [DW-1:0] got[$];
  int          tests, fails;

  always #5 clk = ~clk;

  acc_c_rob dut (
    .clk_i(clk), .rst_i(rst),
    .slv_q_req_i(req), .slv_q_wb_i(wb), .slv_q_valid_i(qv), .slv_q_ready_o(slv_q_ready_o),
    .mst_q_req_o(mst_q_req_o), .mst_q_id_o(mst_q_id_o), .mst_q_valid_o(mst_q_valid_o),
    .mst_q_ready_i(qr),
    .mst_p_rsp_i(prsp), .mst_p_id_i(pid), .mst_p_valid_i(pv), .mst_p_ready_o(mst_p_ready_o),
    .slv_p_rsp_o(slv_p_rsp_o), .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(pr),
    .spurious_o(spurious_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [REQW-1:0] rand_req();
    return REQW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic set_in(input bit a_qv, input bit a_wb, input bit a_qr, input bit a_pv,
                        input int a_pid, input logic [DW-1:0] d0, input bit a_pr);
    qv = a_qv; wb = a_wb; qr = a_qr; pv = a_pv; pid = IW'(a_pid); pr = a_pr;
    req  = rand_req();
    prsp = {d0, ~d0, d0[7:0]};
  endtask

  // Check one cycle against the queue model, then advance the model across the clock edge.
  task automatic step();
    bit full, blk, ok, byp, ev, pop, push;
    int idx;
    logic [RSPW-1:0] erd;
    #1;
    full = (rob.size() == DEPTH);
    blk  = wb && full;
    chk("mst_q_valid", mst_q_valid_o, qv && !blk);
    chk("slv_q_ready", slv_q_ready_o, qr && !blk);
    chk("mst_q_id", mst_q_id_o, next_id);
    chk("mst_q_req", mst_q_req_o, req);
    chk("mst_p_ready", mst_p_ready_o, 1);
    chk("spurious", spurious_o, exp_spur);
    idx = -1;
    foreach (rob[i]) if (rob[i].id == int'(pid)) idx = i;
    ok = pv && (idx >= 0);
    if (ok) ok = !rob[idx].done;
    byp = BYP && ok && (idx == 0);
    ev  = ((rob.size() > 0) && rob[0].done) || byp;
    erd = '0;
    chk("slv_p_valid", slv_p_valid_o, ev);
    if (ev) begin
      erd = byp ? prsp : rob[0].data;
      chk("slv_p_rsp", slv_p_rsp_o, erd);
    end
    pop  = ev && pr;
    push = qv && qr && !blk && wb;
    @(posedge clk);
    if (rst) begin
      rob.delete();
      next_id  = 0;
      exp_spur = 1'b0;
    end else begin
      exp_spur = pv && !ok;
      if (ok && !(byp && pop)) begin
        rob[idx].done = 1'b1;
        rob[idx].data = prsp;
      end
      if (pop) begin
        got.push_back(erd[RSPW-1 -: DW]);
        void'(rob.pop_front());
      end
      if (push) begin
        rob.push_back('{next_id, 1'b0, '0});
        next_id = (next_id + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit a_qv, input bit a_wb, input bit a_qr, input bit a_pv,
                       input int a_pid, input logic [DW-1:0] d0, input bit a_pr);
    set_in(a_qv, a_wb, a_qr, a_pv, a_pid, d0, a_pr);
    step();
  endtask

  task automatic do_rst();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; next_id = 0; exp_spur = 1'b0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_valid", slv_p_valid_o, 0);
    chk("rst_spur", spurious_o, 0);
    chk("rst_id", mst_q_id_o, 0);
    chk("rst_pready", mst_p_ready_o, 1);
    step();

    // Out-of-order responses come back in request order
    repeat (3) drive(1, 1, 1, 0, 0, 0, 0);
    got.delete();
    drive(0, 0, 0, 1, 2, 32'hC, 1);
    drive(0, 0, 0, 1, 0, 32'hA, 1);
    drive(0, 0, 0, 1, 1, 32'hB, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
    chk("order_cnt", got.size(), 3);
    if (got.size() >= 3) begin
      chk("order0", got[0], 32'hA);
      chk("order1", got[1], 32'hB);
      chk("order2", got[2], 32'hC);
    end

    // Fill, block, release, wrap
    do_rst();
    repeat (4) drive(1, 1, 1, 0, 0, 0, 0);
    set_in(1, 1, 1, 0, 0, 0, 0);
    #1 chk("full_block", slv_q_ready_o, 0);
    step();
    drive(1, 1, 1, 1, 0, 32'h1, 0);
    set_in(1, 1, 1, 0, 0, 0, 1);
    #1 chk("release_same_cycle_block", slv_q_ready_o, 0);
    step();
    set_in(1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("wrap_ready", slv_q_ready_o, 1);
    chk("wrap_id", mst_q_id_o, 0);
    step();

    // Non-wb request while full
    set_in(1, 0, 1, 0, 0, 0, 0);
    #1 chk("nowb_full_ready", slv_q_ready_o, 1);
    step();
    set_in(1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("nowb_id_kept", mst_q_id_o, 1);
    chk("nowb_still_full", slv_q_ready_o, 0);
    step();

    // Spurious responses: unallocated id and duplicate
    do_rst();
    repeat (3) drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 32'h5, 0);
    drive(0, 0, 0, 1, 3, 32'h7, 0);
    set_in(0, 0, 0, 1, 0, 32'h9, 0);
    #1 chk("spur_unalloc", spurious_o, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("spur_dup", spurious_o, 1);
    chk("spur_rsp_kept", slv_p_rsp_o[RSPW-1 -: DW], 32'h5);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("spur_one_cycle", spurious_o, 0);
    step();

    // Head response latency, then reset with outstanding entries
    do_rst();
    drive(1, 1, 1, 0, 0, 0, 0);
    set_in(0, 0, 0, 1, 0, 32'h3, 1);
    #1 chk("head_lat_same", slv_p_valid_o, BYP);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1);
    #1 chk("head_lat_next", slv_p_valid_o, !BYP);
    step();
    repeat (2) drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 32'h4, 0);
    do_rst();
    set_in(0, 0, 0, 1, 1, 32'h6, 0);
    #1 chk("rst_drop_valid", slv_p_valid_o, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 chk("stale_id_spur", spurious_o, 1);
    step();
    repeat (4) drive(1, 1, 1, 0, 0, 0, 0);
    set_in(1, 1, 1, 0, 0, 0, 0);
    #1 chk("rst_count_zero", slv_q_ready_o, 0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      qv   = 1'($urandom_range(0, 1));
      wb   = ($urandom_range(0, 3) != 0);
      qr   = ($urandom_range(0, 3) != 0);
      req  = rand_req();
      pv   = 1'($urandom_range(0, 1));
      pid  = IW'($urandom_range(0, DEPTH - 1));
      if ((rob.size() > 0) && ($urandom_range(0, 3) != 0))
        pid = IW'(rob[$urandom_range(0, rob.size() - 1)].id);
      prsp = {$urandom, $urandom, 8'($urandom)};
      pr   = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
